// File: rtl/laser_feeder_if.sv
// Host/LASER-facing signal bundle for laser_feeder.
// The feeder connects through the slave modport; the host/LASER side uses master.
interface laser_feeder_if;
    // host write port and run control
    logic       WR_EN;
    logic [5:0] WR_ADDR;
    logic [3:0] WR_X;
    logic [3:0] WR_Y;
    logic       START;
    logic       BUSY;

    // stream towards LASER
    logic       LRST;
    logic [3:0] X;
    logic [3:0] Y;
    logic       XY_VLD;

    // result coming back from LASER
    logic [3:0] C1X;
    logic [3:0] C1Y;
    logic [3:0] C2X;
    logic [3:0] C2Y;
    logic       DONE;

    // captured and scored results
    logic [3:0] RES_C1X;
    logic [3:0] RES_C1Y;
    logic [3:0] RES_C2X;
    logic [3:0] RES_C2Y;
    logic [5:0] COVER;
    logic       RES_VALID;
    logic       TIMEOUT_ERR;

    modport master (
        output WR_EN, WR_ADDR, WR_X, WR_Y, START,
        output C1X, C1Y, C2X, C2Y, DONE,
        input  BUSY, LRST, X, Y, XY_VLD,
        input  RES_C1X, RES_C1Y, RES_C2X, RES_C2Y, COVER, RES_VALID, TIMEOUT_ERR
    );

    modport slave (
        input  WR_EN, WR_ADDR, WR_X, WR_Y, START,
        input  C1X, C1Y, C2X, C2Y, DONE,
        output BUSY, LRST, X, Y, XY_VLD,
        output RES_C1X, RES_C1Y, RES_C2X, RES_C2Y, COVER, RES_VALID, TIMEOUT_ERR
    );
endinterface

// File: rtl/laser_feeder.sv
// Buffers a 40-point pattern, streams it into LASER, captures the two centers and
// scores coverage. Coverage scoring is compiled in only when LASER_SCORE_EN is defined.
module laser_feeder #(
    parameter int LEAD    = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic          CLK,
    input  logic          RST,
    laser_feeder_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LRST, S_LEAD, S_STREAM, S_WAIT, S_SCORE, S_REPORT
    } state_t;

    state_t     r_state;
    logic [7:0] r_buf [40];
    logic [9:0] r_cnt;
    logic [5:0] r_idx;
    logic       r_cap;
    logic       r_lrst;
    logic [3:0] r_x;
    logic [3:0] r_y;
    logic       r_xy_vld;
    logic       r_busy;
    logic       r_res_valid;
    logic       r_terr;
    logic [3:0] r_c1x;
    logic [3:0] r_c1y;
    logic [3:0] r_c2x;
    logic [3:0] r_c2y;
    logic [5:0] r_cover;

    logic       w_wr_ok;

    assign w_wr_ok = bus.WR_EN && (r_state == S_IDLE) && (bus.WR_ADDR < 6'd40);

    // Pattern storage has no reset so a mid-run abort keeps the loaded points.
    always_ff @(posedge CLK) begin
        if (w_wr_ok)
            r_buf[bus.WR_ADDR] <= {bus.WR_X, bus.WR_Y};
    end

`ifdef LASER_SCORE_EN
    logic [3:0] w_px;
    logic [3:0] w_py;
    logic [3:0] w_cx [2];
    logic [3:0] w_cy [2];
    logic [1:0] w_hit;

    assign w_px    = r_buf[r_idx][7:4];
    assign w_py    = r_buf[r_idx][3:0];
    assign w_cx[0] = r_c1x;
    assign w_cy[0] = r_c1y;
    assign w_cx[1] = r_c2x;
    assign w_cy[1] = r_c2y;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_circle
            logic [3:0] w_dx;
            logic [3:0] w_dy;
            logic [7:0] w_dx2;
            logic [7:0] w_dy2;
            logic [8:0] w_d2;

            assign w_dx  = (w_px >= w_cx[gi]) ? (w_px - w_cx[gi]) : (w_cx[gi] - w_px);
            assign w_dy  = (w_py >= w_cy[gi]) ? (w_py - w_cy[gi]) : (w_cy[gi] - w_py);
            assign w_dx2 = {4'd0, w_dx} * {4'd0, w_dx};
            assign w_dy2 = {4'd0, w_dy} * {4'd0, w_dy};
            assign w_d2  = {1'b0, w_dx2} + {1'b0, w_dy2};
            assign w_hit[gi] = (w_d2 <= 9'd16);
        end
    endgenerate
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_cap       <= 1'b0;
            r_lrst      <= 1'b1;
            r_x         <= '0;
            r_y         <= '0;
            r_xy_vld    <= 1'b0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_terr      <= 1'b0;
            r_c1x       <= '0;
            r_c1y       <= '0;
            r_c2x       <= '0;
            r_c2y       <= '0;
            r_cover     <= '0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.START) begin
                        r_state <= S_LRST;
                        r_busy  <= 1'b1;
                        r_terr  <= 1'b0;
                    end
                end
                S_LRST: begin
                    r_state  <= S_LEAD;
                    r_lrst   <= 1'b0;
                    r_x      <= r_buf[0][7:4];
                    r_y      <= r_buf[0][3:0];
                    r_xy_vld <= 1'b1;
                    r_cnt    <= '0;
                end
                S_LEAD: begin
                    if (r_cnt == 10'(LEAD - 1)) begin
                        r_state <= S_STREAM;
                        r_idx   <= 6'd1;
                        r_x     <= r_buf[1][7:4];
                        r_y     <= r_buf[1][3:0];
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                S_STREAM: begin
                    if (r_idx == 6'd39) begin
                        r_state  <= S_WAIT;
                        r_xy_vld <= 1'b0;
                        r_cnt    <= '0;
                        r_cap    <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                        r_x   <= r_buf[r_idx + 6'd1][7:4];
                        r_y   <= r_buf[r_idx + 6'd1][3:0];
                    end
                end
                S_WAIT: begin
                    // After DONE, one capture cycle passes before leaving WAIT.
                    if (r_cap) begin
`ifdef LASER_SCORE_EN
                        r_state <= S_SCORE;
                        r_idx   <= '0;
                        r_cover <= '0;
`else
                        r_state     <= S_REPORT;
                        r_res_valid <= 1'b1;
`endif
                    end else if (bus.DONE) begin
                        r_cap <= 1'b1;
                        r_c1x <= bus.C1X;
                        r_c1y <= bus.C1Y;
                        r_c2x <= bus.C2X;
                        r_c2y <= bus.C2Y;
                    end else if (r_cnt == 10'(TIMEOUT)) begin
                        r_state     <= S_REPORT;
                        r_res_valid <= 1'b1;
                        r_terr      <= 1'b1;
                        r_c1x       <= '0;
                        r_c1y       <= '0;
                        r_c2x       <= '0;
                        r_c2y       <= '0;
                        r_cover     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
`ifdef LASER_SCORE_EN
                S_SCORE: begin
                    if (|w_hit)
                        r_cover <= r_cover + 6'd1;
                    if (r_idx == 6'd39) begin
                        r_state     <= S_REPORT;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
`endif
                S_REPORT: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_lrst  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.BUSY        = r_busy;
    assign bus.LRST        = r_lrst;
    assign bus.X           = r_x;
    assign bus.Y           = r_y;
    assign bus.XY_VLD      = r_xy_vld;
    assign bus.RES_C1X     = r_c1x;
    assign bus.RES_C1Y     = r_c1y;
    assign bus.RES_C2X     = r_c2x;
    assign bus.RES_C2Y     = r_c2y;
    assign bus.COVER       = r_cover;
    assign bus.RES_VALID   = r_res_valid;
    assign bus.TIMEOUT_ERR = r_terr;
endmodule

// File: tb/tb_laser_feeder.sv
// Randomized self-checking bench for laser_feeder; expected stream timing and coverage
// come from a point-array model and plain distance arithmetic.
module tb_laser_feeder;
    localparam int LEAD    = 2;
    localparam int TIMEOUT = 60;
`ifdef LASER_SCORE_EN
    localparam int LAT = 42;
`else
    localparam int LAT = 2;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;
    int   run_no = 0;

    logic [3:0] mdl_x [40];
    logic [3:0] mdl_y [40];

    laser_feeder_if bus ();

    laser_feeder #(.LEAD(LEAD), .TIMEOUT(TIMEOUT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    wire [15:0] res_all = {bus.RES_C1X, bus.RES_C1Y, bus.RES_C2X, bus.RES_C2Y};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int a, input logic [3:0] x, input logic [3:0] y);
        bus.WR_EN   = 1'b1;
        bus.WR_ADDR = 6'(a);
        bus.WR_X    = x;
        bus.WR_Y    = y;
        step();
        bus.WR_EN = 1'b0;
        if (a < 40) begin
            mdl_x[a] = x;
            mdl_y[a] = y;
        end
    endtask

    function automatic int model_cover(input int c1x, input int c1y, input int c2x, input int c2y);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            int ax, ay, bx, by;
            ax = int'(mdl_x[i]) - c1x;
            ay = int'(mdl_y[i]) - c1y;
            bx = int'(mdl_x[i]) - c2x;
            by = int'(mdl_y[i]) - c2y;
            if (ax * ax + ay * ay <= 16 || bx * bx + by * by <= 16)
                n++;
        end
        return n;
    endfunction

    // One START..REPORT transaction. dly<0: DONE never comes. abort_at>0: RST at that cycle.
    task automatic do_run(input logic [3:0] c1x, input logic [3:0] c1y,
                          input logic [3:0] c2x, input logic [3:0] c2y,
                          input int dly, input int abort_at, input bit wr_same);
        int w, d, rv_at, ecov, pi;
        logic [15:0] ctr;
        w     = LEAD + 41;
        d     = (dly < 0) ? -1 : w + dly;
        rv_at = (dly < 0) ? (w + TIMEOUT + 1) : (d + LAT);
        ctr   = {c1x, c1y, c2x, c2y};
        run_no++;

        bus.START = 1'b1;
        if (wr_same) begin
            int a;
            a = int'($urandom_range(0, 39));
            bus.WR_EN   = 1'b1;
            bus.WR_ADDR = 6'(a);
            bus.WR_X    = 4'($urandom);
            bus.WR_Y    = 4'($urandom);
            mdl_x[a]    = bus.WR_X;
            mdl_y[a]    = bus.WR_Y;
        end
        step();
        bus.START = 1'b0;
        bus.WR_EN = 1'b0;

`ifdef LASER_SCORE_EN
        ecov = (dly < 0) ? 0 : model_cover(int'(c1x), int'(c1y), int'(c2x), int'(c2y));
`else
        ecov = 0;
`endif

        for (int t = 1; t <= rv_at + 1; t++) begin
            if (t == abort_at) begin
                RST = 1'b1;
                #1;
                chk("abort_ctl", 32'({bus.LRST, bus.BUSY, bus.XY_VLD, bus.RES_VALID, bus.TIMEOUT_ERR}), 32'h10);
                chk("abort_xy", 32'({bus.X, bus.Y}), 32'h0);
                chk("abort_res", 32'({res_all, bus.COVER}), 32'h0);
                step();
                step();
                RST = 1'b0;
                for (int k = 0; k < 100; k++) begin
                    step();
                    chk("abort_idle", 32'({bus.RES_VALID, bus.BUSY, bus.LRST}), 32'h1);
                end
                $display("run %0d: aborted at cycle %0d", run_no, abort_at);
                return;
            end

            chk("busy", 32'(bus.BUSY), 32'(t <= rv_at));
            chk("lrst", 32'(bus.LRST), 32'(t <= 1 || t > rv_at));
            chk("res_valid", 32'(bus.RES_VALID), 32'(t == rv_at));
            if (t >= 2 && t <= LEAD + 40) begin
                pi = (t < 2 + LEAD) ? 0 : t - 1 - LEAD;
                chk("stream", 32'({bus.XY_VLD, bus.X, bus.Y}), 32'({1'b1, mdl_x[pi], mdl_y[pi]}));
            end else begin
                chk("xy_vld", 32'(bus.XY_VLD), 32'h0);
            end
            if (t == 1)
                chk("terr_clr", 32'(bus.TIMEOUT_ERR), 32'h0);
            if (dly >= 0 && t == d + 1)
                chk("capture", 32'(res_all), 32'(ctr));
            if (t >= rv_at) begin
                chk("res", 32'(res_all), (dly < 0) ? 32'h0 : 32'(ctr));
                chk("cover", 32'(bus.COVER), 32'(ecov));
                chk("terr", 32'(bus.TIMEOUT_ERR), 32'(dly < 0));
            end

            // Stray DONE before WAIT, plus a write and START while busy: all must be ignored.
            bus.DONE = (t == d) || (t == 10);
            if (t == d) begin
                bus.C1X = c1x; bus.C1Y = c1y; bus.C2X = c2x; bus.C2Y = c2y;
            end else begin
                bus.C1X = 4'($urandom); bus.C1Y = 4'($urandom);
                bus.C2X = 4'($urandom); bus.C2Y = 4'($urandom);
            end
            if (t == 3) begin
                bus.WR_EN   = 1'b1;
                bus.WR_ADDR = 6'($urandom_range(0, 39));
                bus.WR_X    = 4'($urandom);
                bus.WR_Y    = 4'($urandom);
                bus.START   = 1'b1;
            end
            step();
            bus.DONE  = 1'b0;
            bus.WR_EN = 1'b0;
            bus.START = 1'b0;
        end
        $display("run %0d: done_dly=%0d cover=%0d res=%h terr=%0b", run_no, dly, bus.COVER, res_all, bus.TIMEOUT_ERR);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.WR_EN = 1'b0; bus.WR_ADDR = '0; bus.WR_X = '0; bus.WR_Y = '0;
        bus.START = 1'b0; bus.DONE = 1'b0;
        bus.C1X = '0; bus.C1Y = '0; bus.C2X = '0; bus.C2Y = '0;
        RST = 1'b1;
        repeat (3) step();
        chk("rst_ctl", 32'({bus.LRST, bus.BUSY, bus.XY_VLD, bus.RES_VALID, bus.TIMEOUT_ERR}), 32'h10);
        chk("rst_xy", 32'({bus.X, bus.Y}), 32'h0);
        chk("rst_res", 32'({res_all, bus.COVER}), 32'h0);
        RST = 1'b0;
        repeat (3) step();
        chk("idle_ctl", 32'({bus.LRST, bus.BUSY, bus.XY_VLD, bus.RES_VALID, bus.TIMEOUT_ERR}), 32'h10);

        // all points at (5,5), centered hit on C1
        for (int i = 0; i < 40; i++) wr(i, 4'd5, 4'd5);
        wr(45, 4'd9, 4'd9);
        do_run(4'd5, 4'd5, 4'd0, 4'd0, 3, -1, 1'b0);

        // half the points on the radius boundary, half just outside C2
        for (int i = 0; i < 40; i++) begin
            if (i < 20) wr(i, 4'd2, 4'd2);
            else        wr(i, 4'd12, 4'd12);
        end
        do_run(4'd2, 4'd6, 4'd15, 4'd15, 0, -1, 1'b0);

        // no DONE: timeout path, then next START must clear the error
        do_run(4'd1, 4'd2, 4'd3, 4'd4, -1, -1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 40; i++) wr(i, 4'($urandom), 4'($urandom));
            do_run(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                   int'($urandom_range(0, 5)), -1, r[0]);
        end

        // abort mid-stream, then the preserved buffer must stream again
        do_run(4'd7, 4'd7, 4'd8, 4'd8, 2, 20, 1'b0);
        do_run(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/laser_feeder.md
# laser_feeder

Host-side driver for the `LASER` two-circle coverage engine. It buffers one 40-point pattern and holds `LASER` in reset for one cycle. It then streams the points on `X`/`Y`, waits for `DONE` and captures the two reported centers. Finally it scores them by counting how many buffered points lie inside either radius-4 circle. It sits between the test/host controller and `LASER`: `LASER` consumes the stream, and the feeder is the producer and checker.

## Interface
- `LEAD`, default 1: cycles point 0 is held on `X`/`Y` after `LRST` drops, before the index advances (range 1..3).
- `TIMEOUT`, default 1023: maximum `WAIT` cycles for `DONE`; 10-bit counter.
- `CLK` in 1: clock.
- `RST` in 1: reset, asynchronous, active-high.
- `WR_EN`, `WR_ADDR[5:0]`, `WR_X[3:0]`, `WR_Y[3:0]` in: point buffer write. Honoured only when `BUSY`=0 and `WR_ADDR`<40.
- `START` in 1: begin a run. Honoured only when `BUSY`=0.
- `BUSY` out 1: high from the cycle after an accepted `START` until the `REPORT` cycle inclusive.
- `LRST` out 1: reset to `LASER`, registered.
- `X`, `Y` out 4 each: point stream to `LASER`, registered.
- `XY_VLD` out 1: high on every `LEAD`/`STREAM` cycle.
- `C1X`, `C1Y`, `C2X`, `C2Y` in 4 each; `DONE` in 1: result from `LASER`.
- `RES_C1X`, `RES_C1Y`, `RES_C2X`, `RES_C2Y` out 4 each: captured centers.
- `COVER` out 6: covered-point count, 0..40.
- `RES_VALID` out 1: one-cycle pulse when results are final.
- `TIMEOUT_ERR` out 1: set with `RES_VALID` when `DONE` never arrived; cleared on the next accepted `START`.

## Operation
- Buffer: 40×8-bit register array. It is not reset; contents persist across runs.
- States: `IDLE`, `LRST`, `LEAD`, `STREAM`, `WAIT`, `SCORE`, `REPORT`.
- `IDLE` → `LRST` on `START`.
- `LRST`: one cycle, `LRST`=1. Then → `LEAD`.
- `LEAD`: `LEAD` cycles, `X`/`Y` = point 0. Then → `STREAM`.
- `STREAM`: index counts 1..39, one point per cycle; `X`/`Y` = point[idx]. Then → `WAIT`.
- `WAIT`: `X`/`Y` hold point 39.
  - On `DONE`=1, capture `C1X..C2Y` into the `RES_*` registers and → `SCORE`.
  - If the wait counter reaches `TIMEOUT` with no `DONE`: `RES_*`=0, `COVER`=0, `TIMEOUT_ERR`=1, → `REPORT`.
- `SCORE`: 40 cycles, one point per cycle, idx 0..39.
  - `dx` = |px−cx| and `dy` = |py−cy|, each 4-bit unsigned.
  - Squares are 8-bit; their sum is 9-bit.
  - A point is covered if `dx²+dy²` ≤ 16 against C1 or against C2; covered increments `COVER` by 1.
  - `COVER` is cleared on entry to `SCORE`.
- `REPORT`: `RES_VALID`=1 for one cycle, then → `IDLE`.
- A `DONE` seen outside `WAIT` is ignored.
- `START` and `WR_EN` in the same `IDLE` cycle: both are accepted; the written point is streamed.
- `WR_EN` or `START` while `BUSY`: ignored, with no side effect.

## Timing
- Reset values:
  - `LRST`=1.
  - `X`, `Y`, `XY_VLD`, `BUSY`, `RES_VALID`, `TIMEOUT_ERR` = 0.
  - All `RES_*` = 0; `COVER` = 0.
  - State `IDLE`; counters 0.
- `LRST` stays 1 in `IDLE`. It is released on the cycle after `LRST` state, i.e. start+2.
- Point 0 is first visible at start+2. Point k (k≥1) is visible at start+1+`LEAD`+k.
- `RES_*` update on the cycle after `DONE`.
- `RES_VALID` rises `DONE`+42 cycles: 1 capture cycle, 40 `SCORE` cycles, then `REPORT`.
- `RST` mid-run aborts immediately:
  - Back to `IDLE`, outputs at reset values.
  - The buffer is preserved.
  - No `RES_VALID` is issued.
- `RES_*` and `COVER` hold their values until the next run's capture or timeout.

## Configuration
- `LASER_SCORE_EN` defined: `SCORE` state and coverage arithmetic are compiled in, as described above.
- `LASER_SCORE_EN` undefined:
  - `SCORE` is removed; `WAIT` goes to `REPORT` directly on `DONE`.
  - `RES_VALID` arrives at `DONE`+2.
  - `COVER` is tied to 0.

## Test plan
- Reset then idle: all outputs at reset values; `LRST`=1; `BUSY`=0.
- Load 40 points all (5,5), `START`:
  - Stream shows (5,5) from start+2 for `LEAD`+39 cycles.
  - Model returns C1=(5,5), C2=(0,0) → `COVER`=40, `RES_VALID` at `DONE`+42.
- Points 0..19 at (2,2) and points 20..39 at (12,12), centers C1=(2,6), C2=(15,15):
  - Points at (2,2): dist² to C1 = 16 → covered.
  - Points at (12,12): dist² to C2 = 18 → not covered.
  - Expect `COVER`=20.
- No `DONE` driven: `RES_VALID` with `TIMEOUT_ERR`=1, `COVER`=0, `RES_*`=0 at start+2+`LEAD`+39+`TIMEOUT`+1. The next `START` clears `TIMEOUT_ERR`.
- `WR_EN` and `START` pulsed while `BUSY`: the buffer and run are unchanged.
- `RST` asserted mid-`STREAM`: outputs reset and no `RES_VALID`. A following `START` streams the preserved buffer correctly.
